// File: rtl/cnn_3d_relu_maxpool_pkg.sv
// Shared types and helpers for the 3D ReLU + max-pool stage and its coordinate counter.
package cnn_pkg;
    localparam int DATA_W = 16;

    typedef enum logic [1:0] {ACCEPT, DRAIN, FINISH} state_t;

    function automatic int pool_out_size(input int vol_size, input int pool);
        return vol_size / pool;
    endfunction

    // Counter/index width that never collapses to zero bits.
    function automatic int width_of(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/cnn_3d_relu_maxpool_if.sv
// Input sample stream, pooled output stream and frame-done pulse of the ReLU/max-pool stage.
interface cnn_3d_relu_maxpool_if #(parameter int DATA_W = cnn_pkg::DATA_W);
    logic                     in_valid;
    logic                     in_ready;
    logic signed [DATA_W-1:0] in_data;
    logic                     out_valid;
    logic                     out_ready;
    logic [DATA_W-1:0]        out_data;
    logic [15:0]              out_idx;
    logic                     out_last;
    logic                     done;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_idx, out_last, done
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_idx, out_last, done
    );
endinterface

// File: rtl/cnn_3d_relu_maxpool_coord_counter.sv
// Four-level wrapping coordinate counter (col fastest, then row, depth, filter) with
// pooling-window first/closing flags and an end-of-frame flag.
module cnn_coord_counter #(
    parameter int VOL_SIZE    = 4,
    parameter int POOL        = 2,
    parameter int NUM_FILTERS = 3,
    parameter int VW          = cnn_pkg::width_of(VOL_SIZE),
    parameter int FW          = cnn_pkg::width_of(NUM_FILTERS)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          advance,
    output logic [VW-1:0] col,
    output logic [VW-1:0] row,
    output logic [VW-1:0] depth,
    output logic [FW-1:0] filt,
    output logic          first,
    output logic          closing,
    output logic          last
);
    localparam logic [VW-1:0] VMAX = VW'(VOL_SIZE - 1);
    localparam logic [FW-1:0] FMAX = FW'(NUM_FILTERS - 1);

    function automatic logic at_phase(input logic [VW-1:0] v, input int ph);
        return (int'(v) % POOL) == ph;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            col   <= '0;
            row   <= '0;
            depth <= '0;
            filt  <= '0;
        end else if (advance) begin
            if (col == VMAX) begin
                col <= '0;
                if (row == VMAX) begin
                    row <= '0;
                    if (depth == VMAX) begin
                        depth <= '0;
                        filt  <= (filt == FMAX) ? '0 : filt + FW'(1);
                    end else begin
                        depth <= depth + VW'(1);
                    end
                end else begin
                    row <= row + VW'(1);
                end
            end else begin
                col <= col + VW'(1);
            end
        end
    end

    always_comb begin
        first   = at_phase(col, 0) && at_phase(row, 0) && at_phase(depth, 0);
        closing = at_phase(col, POOL-1) && at_phase(row, POOL-1) && at_phase(depth, POOL-1);
        last    = closing && (filt == FMAX) && (depth == VMAX) && (row == VMAX) && (col == VMAX);
    end
endmodule

// File: rtl/cnn_3d_relu_maxpool.sv
// ReLU followed by non-overlapping POOL^3 max pooling over a streamed conv output volume.
module cnn_3d_relu_maxpool
    import cnn_pkg::*;
#(
    parameter int VOL_SIZE    = 4,
    parameter int POOL        = 2,
    parameter int NUM_FILTERS = 3,
    parameter int DATA_W      = cnn_pkg::DATA_W
) (
    input logic clk,
    input logic reset,
    cnn_3d_relu_maxpool_if.slave bus
);
    localparam int PV = pool_out_size(VOL_SIZE, POOL);
    localparam int VW = width_of(VOL_SIZE);
    localparam int FW = width_of(NUM_FILTERS);
    localparam int BW = width_of(PV * PV);

    generate
        if (VOL_SIZE % POOL != 0) begin : g_bad_pool
            $error("VOL_SIZE must be a multiple of POOL");
        end
    endgenerate

    state_t                   state, state_nxt;
    logic                     in_ready, in_xfer, out_xfer, done;
    logic [VW-1:0]            col, row, depth;
    logic [FW-1:0]            filt;
    logic                     first, closing, last;
    logic [BW-1:0]            bidx;
    logic [15:0]              idx_nxt;
    logic signed [DATA_W-1:0] x, cur;
    logic signed [DATA_W-1:0] pbuf [PV*PV];
    logic                     out_valid_q, out_last_q;
    logic [DATA_W-1:0]        out_data_q;
    logic [15:0]              out_idx_q;

    cnn_coord_counter #(
        .VOL_SIZE(VOL_SIZE), .POOL(POOL), .NUM_FILTERS(NUM_FILTERS), .VW(VW), .FW(FW)
    ) u_coord (
        .clk(clk), .reset(reset), .advance(in_xfer),
        .col(col), .row(row), .depth(depth), .filt(filt),
        .first(first), .closing(closing), .last(last)
    );

    assign in_xfer  = bus.in_valid && in_ready;
    assign out_xfer = out_valid_q && bus.out_ready;

    // The partial-max buffer covers one pooled depth slice and is reused for the next one.
    always_comb begin
        bidx    = BW'((int'(row) / POOL) * PV + int'(col) / POOL);
        idx_nxt = 16'(int'(filt) * PV * PV * PV + (int'(depth) / POOL) * PV * PV
                      + (int'(row) / POOL) * PV + int'(col) / POOL);
        x       = bus.in_data[DATA_W-1] ? '0 : bus.in_data;
        cur     = first ? x : ((x > pbuf[bidx]) ? x : pbuf[bidx]);
    end

    always_ff @(posedge clk) begin
        if (in_xfer) pbuf[bidx] <= cur;
    end

    // A closing sample may reload the register in the same cycle the old result leaves.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_idx_q   <= '0;
            out_last_q  <= 1'b0;
        end else if (in_xfer && closing) begin
            out_valid_q <= 1'b1;
            out_data_q  <= cur;
            out_idx_q   <= idx_nxt;
            out_last_q  <= last;
        end else if (out_xfer) begin
            out_valid_q <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state <= ACCEPT;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ACCEPT: if (in_xfer && last) state_nxt = DRAIN;
            DRAIN:  if (out_xfer && out_last_q) state_nxt = FINISH;
            FINISH: state_nxt = ACCEPT;
            default: state_nxt = ACCEPT;
        endcase
    end

    always_comb begin
        in_ready = (state == ACCEPT) && (!out_valid_q || bus.out_ready);
        done     = (state == FINISH);
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_idx   = out_idx_q;
    assign bus.out_last  = out_last_q;
    assign bus.done      = done;
endmodule

// File: tb/tb_cnn_3d_relu_maxpool.sv
// Scoreboard bench for cnn_3d_relu_maxpool (VOL_SIZE=4, POOL=2, NUM_FILTERS=3).
module tb_cnn_3d_relu_maxpool;
    typedef struct packed {
        logic [15:0] data;
        logic [15:0] idx;
        logic        last;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   nvec = 0;
    int   nerr = 0;
    int   rmode = 0;
    int   done_cnt = 0;
    exp_t q[$];

    cnn_3d_relu_maxpool_if #(.DATA_W(16)) bus();

    cnn_3d_relu_maxpool #(
        .VOL_SIZE(4), .POOL(2), .NUM_FILTERS(3), .DATA_W(16)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    // kind 0: ramp, 1: all -5, 2: extreme values in the first blocks
    function automatic logic [15:0] sample(input int kind, input int i);
        case (kind)
            0: return 16'(i);
            1: return 16'hFFFB;
            default: return (i == 0) ? 16'h7FFF : ((i == 1 || i == 2) ? 16'h8000 : 16'h0000);
        endcase
    endfunction

    // Hand-derived block maxima: for a ramp the max of a 2x2x2 block is its far corner.
    function automatic int expected(input int kind, input int b);
        int f, pd, pr, pc;
        f = b / 8; pd = (b / 4) % 2; pr = (b / 2) % 2; pc = b % 2;
        case (kind)
            0: return f * 64 + (2 * pd + 1) * 16 + (2 * pr + 1) * 4 + 2 * pc + 1;
            1: return 0;
            default: return (b == 0) ? 32767 : 0;
        endcase
    endfunction

    // out_ready driver: 0 = always high, 1 = random, 2 = held low
    always @(posedge clk) begin
        #1;
        case (rmode)
            0: bus.out_ready = 1'b1;
            1: bus.out_ready = 1'($urandom_range(0, 1));
            default: bus.out_ready = 1'b0;
        endcase
    end

    // Monitor: pops the scoreboard on every output handshake, checks hold and done timing.
    logic        stalled = 1'b0, last_hs = 1'b0;
    logic [15:0] hold_data, hold_idx;
    logic        hold_last;
    always @(negedge clk) begin
        if (reset) begin
            stalled = 1'b0;
            last_hs = 1'b0;
        end else begin
            if (stalled) begin
                chk("hold_valid", 32'(bus.out_valid), 1);
                chk("hold_data", 32'(bus.out_data), 32'(hold_data));
                chk("hold_idx", 32'(bus.out_idx), 32'(hold_idx));
                chk("hold_last", 32'(bus.out_last), 32'(hold_last));
            end
            if (bus.out_valid && !bus.out_ready) chk("in_ready_stall", 32'(bus.in_ready), 0);
            if (bus.done || last_hs) chk("done_timing", 32'(bus.done), 32'(last_hs));
            if (bus.done) done_cnt++;
            last_hs = bus.out_valid && bus.out_ready && bus.out_last;
            if (bus.out_valid && bus.out_ready) begin
                if (q.size() == 0) begin
                    chk("out_unexpected", 32'(q.size()), 1);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("out_data", 32'(bus.out_data), 32'(e.data));
                    chk("out_idx", 32'(bus.out_idx), 32'(e.idx));
                    chk("out_last", 32'(bus.out_last), 32'(e.last));
                end
            end
            stalled   = bus.out_valid && !bus.out_ready;
            hold_data = bus.out_data;
            hold_idx  = bus.out_idx;
            hold_last = bus.out_last;
        end
    end

    initial begin
        repeat (60000) @(posedge clk);
        $display("FAIL watchdog: simulation exceeded cycle budget");
        $fatal(1, "watchdog");
    end

    task automatic push_exp(input int kind, input int n);
        for (int b = 0; b < n; b++)
            q.push_back('{data: 16'(expected(kind, b)), idx: 16'(b), last: (b == 23)});
    endtask

    // Called at a negedge; returns at the negedge after the accepting posedge.
    task automatic send(input logic [15:0] v);
        bit ok;
        int n;
        bus.in_valid = 1'b1;
        bus.in_data  = v;
        n = 0;
        do begin
            ok = bus.in_ready;
            @(negedge clk);
            n++;
        end while (!ok && n < 1000);
        if (!ok) chk("in_accept_timeout", 32'(ok), 1);
    endtask

    task automatic send_frame(input int kind, input int count, input bit gaps);
        for (int i = 0; i < count; i++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                bus.in_valid = 1'b0;
                repeat ($urandom_range(1, 3)) @(negedge clk);
            end
            send(sample(kind, i));
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic finish_frame(input int done_before, input int done_exp);
        int n = 0;
        while (q.size() != 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("drain_left", 32'(q.size()), 0);
        repeat (4) @(negedge clk);
        chk("done_count", 32'(done_cnt - done_before), 32'(done_exp));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.in_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        int d0;
        reset = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        chk("rst_out_valid", 32'(bus.out_valid), 0);
        chk("rst_out_data", 32'(bus.out_data), 0);
        chk("rst_out_idx", 32'(bus.out_idx), 0);
        chk("rst_out_last", 32'(bus.out_last), 0);
        chk("rst_done", 32'(bus.done), 0);
        chk("rst_in_ready", 32'(bus.in_ready), 1);

        // Ramp, out_ready high
        d0 = done_cnt;
        push_exp(0, 24);
        send_frame(0, 192, 1'b0);
        finish_frame(d0, 1);

        // ReLU clamps everything to zero
        d0 = done_cnt;
        push_exp(1, 24);
        send_frame(1, 192, 1'b0);
        finish_frame(d0, 1);

        // Ten-cycle stall on the first output
        d0 = done_cnt;
        rmode = 2;
        push_exp(0, 24);
        fork
            send_frame(0, 192, 1'b0);
            begin
                int n = 0;
                while (!bus.out_valid && n < 500) begin
                    @(negedge clk);
                    n++;
                end
                chk("stall_first_valid", 32'(bus.out_valid), 1);
                repeat (10) @(posedge clk);
                rmode = 0;
            end
        join
        finish_frame(d0, 1);

        // Random input gaps and random backpressure
        d0 = done_cnt;
        rmode = 1;
        push_exp(0, 24);
        send_frame(0, 192, 1'b1);
        finish_frame(d0, 1);
        rmode = 0;
        repeat (2) @(negedge clk);

        // Signed extremes
        d0 = done_cnt;
        push_exp(2, 24);
        send_frame(2, 192, 1'b0);
        finish_frame(d0, 1);

        // Abort after 50 samples: the four blocks closed so far come out before reset
        d0 = done_cnt;
        push_exp(0, 4);
        send_frame(0, 50, 1'b0);
        repeat (3) @(negedge clk);
        chk("abort_left", 32'(q.size()), 0);
        do_reset();
        chk("abort_out_valid", 32'(bus.out_valid), 0);
        push_exp(0, 24);
        send_frame(0, 192, 1'b0);
        finish_frame(d0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
